// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller and the cache block:
// controller state encoding and default width constants.
package cache_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int TAG_W_DEF   = 8;
  localparam int INDEX_W_DEF = 6;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_LOOKUP = 3'd1,
    RD_CHECK  = 3'd2,
    MEM_RD    = 3'd3,
    FILL      = 3'd4,
    WR_CACHE  = 3'd5,
    WR_MEM    = 3'd6,
    DONE      = 3'd7
  } cache_state_e;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Saturating increment register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/cache_ctrl.sv
// Write-through, no-allocate cache controller sitting between a CPU port,
// a registered cache array and a word-addressed memory.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int DATALENGTH  = DATA_W_DEF,
  parameter int TAGLENGTH   = TAG_W_DEF,
  parameter int INDEXLENGTH = INDEX_W_DEF,
  parameter int CNTW        = CNT_W_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cpu_req,
  input  logic                             cpu_we,
  input  logic [TAGLENGTH+INDEXLENGTH-1:0] cpu_addr,
  input  logic [DATALENGTH-1:0]            cpu_wdata,
  output logic                             cpu_done,
  output logic [DATALENGTH-1:0]            cpu_rdata,
  output logic                             cpu_busy,
  output logic [TAGLENGTH-1:0]             c_tag,
  output logic [INDEXLENGTH-1:0]           c_index,
  output logic                             c_re,
  output logic                             c_we,
  output logic                             c_loade,
  output logic [DATALENGTH-1:0]            c_datain,
  input  logic                             c_hit,
  input  logic [DATALENGTH-1:0]            c_dataout,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [TAGLENGTH+INDEXLENGTH-1:0] mem_addr,
  output logic [DATALENGTH-1:0]            mem_wdata,
  input  logic                             mem_ack,
  input  logic [DATALENGTH-1:0]            mem_rdata,
  output logic [CNTW-1:0]                  hit_cnt,
  output logic [CNTW-1:0]                  miss_cnt
);

  localparam int AW = TAGLENGTH + INDEXLENGTH;

  cache_state_e state_r, state_s;
  logic [AW-1:0]         addr_r;
  logic [DATALENGTH-1:0] wdata_r;
  logic [DATALENGTH-1:0] rdata_r;
  logic cpu_done_r, cpu_busy_r, c_re_r, c_we_r, c_loade_r, mem_req_r, mem_we_r;
  logic hit_inc_s, miss_inc_s;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; mem_ack only matters in the two memory states
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:      if (cpu_req) state_s = cpu_we ? WR_CACHE : RD_LOOKUP;
                 else         state_s = IDLE;
      RD_LOOKUP: state_s = RD_CHECK;
      RD_CHECK:  state_s = c_hit ? DONE : MEM_RD;
      MEM_RD:    if (mem_ack) state_s = FILL;
                 else         state_s = MEM_RD;
      FILL:      state_s = DONE;
      WR_CACHE:  state_s = WR_MEM;
      WR_MEM:    if (mem_ack) state_s = DONE;
                 else         state_s = WR_MEM;
      DONE:      state_s = IDLE;
      default:   state_s = IDLE;
    endcase
  end

  assign hit_inc_s  = (state_r == RD_CHECK) &&  c_hit;
  assign miss_inc_s = (state_r == RD_CHECK) && !c_hit;

  // Strobes are registered from the next state so each lines up with its state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_done_r <= 1'b0;
      cpu_busy_r <= 1'b0;
      c_re_r     <= 1'b0;
      c_we_r     <= 1'b0;
      c_loade_r  <= 1'b0;
      mem_req_r  <= 1'b0;
      mem_we_r   <= 1'b0;
    end else begin
      cpu_done_r <= (state_s == DONE);
      cpu_busy_r <= (state_s != IDLE);
      c_re_r     <= (state_s == RD_LOOKUP);
      c_we_r     <= (state_s == WR_CACHE);
      c_loade_r  <= (state_s == FILL);
      mem_req_r  <= (state_s == MEM_RD) || (state_s == WR_MEM);
      mem_we_r   <= (state_s == WR_MEM);
    end
  end

  // Request capture and read-data return path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r  <= {AW{1'b0}};
      wdata_r <= {DATALENGTH{1'b0}};
      rdata_r <= {DATALENGTH{1'b0}};
    end else begin
      if ((state_r == IDLE) && cpu_req) begin
        addr_r  <= cpu_addr;
        wdata_r <= cpu_wdata;
      end
      if (hit_inc_s) begin
        rdata_r <= c_dataout;
      end else if ((state_r == MEM_RD) && mem_ack) begin
        rdata_r <= mem_rdata;
      end
    end
  end

  sat_counter #(.W(CNTW)) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit_inc_s),
    .count (hit_cnt)
  );

  sat_counter #(.W(CNTW)) u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (miss_inc_s),
    .count (miss_cnt)
  );

  // The fill word is the memory word already returned to the CPU
  assign c_datain  = (state_r == FILL) ? rdata_r : wdata_r;
  assign c_tag     = addr_r[AW-1 -: TAGLENGTH];
  assign c_index   = addr_r[INDEXLENGTH-1:0];
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign cpu_rdata = rdata_r;
  assign cpu_done  = cpu_done_r;
  assign cpu_busy  = cpu_busy_r;
  assign c_re      = c_re_r;
  assign c_we      = c_we_r;
  assign c_loade   = c_loade_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;

endmodule
